// File: rtl/mem_access_unit.sv
// Memory-access sequencer: serialises fetch/load/store requests over a valid/ack
// memory port, aligns byte lanes, extends load data and reports access errors.
module mem_access_unit #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = 'h1000,
   parameter int                TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_kind,
   input  logic [2:0]          funct3,
   input  logic [XLEN-1:0]     addr,
   input  logic [XLEN-1:0]     wdata,
   output logic                done,
   output logic                err,
   output logic [31:0]         instr_out,
   output logic [XLEN-1:0]     old_pc_out,
   output logic [XLEN-1:0]     load_data,
   output logic                mem_req,
   output logic                mem_we,
   output logic [XLEN-1:0]     mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int          BEW      = XLEN / 8;
   localparam int          OFFW     = $clog2(BEW);
   localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;
   typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE, K_ILL} kind_t;

   state_t             r_state, w_next;
   logic [1:0]         r_kind;
   logic [2:0]         r_funct3;
   logic [XLEN-1:0]    r_addr;
   logic [7:0]         r_cnt;
   logic               r_err;
   logic [31:0]        r_instr;
   logic [XLEN-1:0]    r_old_pc, r_load;
   logic [XLEN-1:0]    r_mem_addr, r_mem_wdata;
   logic [BEW-1:0]     r_mem_be;

   // Request decode, evaluated on the raw inputs while in IDLE.
   logic [1:0]         w_size;
   logic               w_f3_ok, w_misal, w_legal;
   logic [OFFW-1:0]    w_off;
   logic [7:0]         w_mask;
   logic [BEW-1:0]     w_be;

   assign w_size = (req_kind == K_FETCH) ? 2'd2 : funct3[1:0];
   assign w_off  = addr[OFFW-1:0];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_f3_ok = 1'b0;
      w_misal = 1'b0;
      w_mask  = 8'h01;
      case (req_kind)
         K_FETCH: w_f3_ok = 1'b1;
         K_LOAD:  w_f3_ok = (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                            ((XLEN == 64) && (funct3 inside {3'd3, 3'd6}));
         K_STORE: w_f3_ok = (funct3 inside {3'd0, 3'd1, 3'd2}) ||
                            ((XLEN == 64) && (funct3 == 3'd3));
         default: w_f3_ok = 1'b0;
      endcase
      case (w_size)
         2'd1:    begin w_misal = addr[0];      w_mask = 8'h03; end
         2'd2:    begin w_misal = |addr[1:0];   w_mask = 8'h0F; end
         2'd3:    begin w_misal = |addr[2:0];   w_mask = 8'hFF; end
         default: begin w_misal = 1'b0;         w_mask = 8'h01; end
      endcase
   end

   assign w_legal = w_f3_ok && !w_misal && (req_kind != K_ILL);
   // Stores place the mask on the addressed lanes; reads request the access size.
   assign w_be    = (req_kind == K_STORE) ? BEW'({8'h00, w_mask} << w_off) : BEW'(w_mask);

   // Read-data alignment and extension from the latched request.
   logic [XLEN-1:0]    w_rd_sh, w_lmask, w_ext;
   logic               w_msb;

   assign w_rd_sh = mem_rdata >> {r_addr[OFFW-1:0], 3'b000};

   always_comb begin
      case (r_funct3[1:0])
         2'd0:    w_lmask = XLEN'(8'hFF);
         2'd1:    w_lmask = XLEN'(16'hFFFF);
         2'd2:    w_lmask = XLEN'(32'hFFFF_FFFF);
         default: w_lmask = '1;
      endcase
   end

   assign w_msb = |(w_rd_sh & w_lmask & ~(w_lmask >> 1));
   assign w_ext = (w_rd_sh & w_lmask) | ((!r_funct3[2] && w_msb) ? ~w_lmask : '0);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = w_legal ? S_ISSUE : S_FIN;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (mem_rvalid || (r_cnt == CNT_LAST)) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_kind      <= '0;
         r_funct3    <= '0;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_instr     <= '0;
         r_old_pc    <= RESET_PC;
         r_load      <= '0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_kind   <= req_kind;
               r_funct3 <= funct3;
               r_addr   <= addr;
               r_err    <= !w_legal;
               if (w_legal) begin
                  r_mem_addr  <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                  r_mem_be    <= w_be;
                  r_mem_wdata <= wdata << {w_off, 3'b000};
               end
            end
            S_ISSUE: r_cnt <= '0;
            S_WAIT: begin
               if (mem_rvalid) begin
                  r_err <= 1'b0;
                  if (r_kind == K_FETCH) begin
                     r_instr  <= w_rd_sh[31:0];
                     r_old_pc <= r_addr;
                  end else if (r_kind == K_LOAD) begin
                     r_load   <= w_ext;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
                  if (r_cnt == CNT_LAST) r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign mem_req    = (r_state == S_ISSUE);
   assign mem_we     = (r_state == S_ISSUE) && (r_kind == K_STORE);
   assign done       = (r_state == S_FIN);
   assign err        = (r_state == S_FIN) && r_err;
   assign instr_out  = r_instr;
   assign old_pc_out = r_old_pc;
   assign load_data  = r_load;
   assign mem_addr   = r_mem_addr;
   assign mem_be     = r_mem_be;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (XLEN=32, TIMEOUT=15).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [1:0]  req_kind;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        done, err;
   logic [31:0] instr_out, old_pc_out, load_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_rvalid;

   int n_tests = 0;
   int n_fail  = 0;

   // Observations from the most recent request.
   int          d_cyc, n_req;
   logic        d_err, s_we;
   logic [3:0]  s_be;
   logic [31:0] s_addr, s_wdata;

   mem_access_unit #(.XLEN(32), .RESET_PC(32'h1000), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .funct3(funct3), .addr(addr), .wdata(wdata),
      .done(done), .err(err), .instr_out(instr_out), .old_pc_out(old_pc_out),
      .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request in cycle 0; raise mem_rvalid in cycle rv_cyc (-1: never).
   // Ends one cycle after done, back in IDLE.
   task automatic run(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int rv_cyc, input logic [31:0] rd);
      req_valid = 1'b1; req_kind = k; funct3 = f3; addr = a; wdata = wd;
      d_cyc = -1; d_err = 1'b0; n_req = 0;
      for (int c = 1; c <= 40 && d_cyc < 0; c++) begin
         step();
         req_valid  = 1'b0;
         mem_rvalid = (c == rv_cyc);
         mem_rdata  = rd;
         if (mem_req) begin
            n_req++;
            s_be = mem_be; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
         end
         if (done) begin
            d_cyc = c;
            d_err = err;
         end
      end
      mem_rvalid = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_kind = 2'd0; funct3 = 3'd0;
      addr = '0; wdata = '0; mem_rvalid = 1'b0; mem_rdata = '0;
      s_be = '0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
      step(); step();
      check("rst_ready",  req_ready,  1'b1);
      check("rst_done",   done,       1'b0);
      check("rst_err",    err,        1'b0);
      check("rst_memreq", mem_req,    1'b0);
      check("rst_be",     mem_be,     4'h0);
      check("rst_maddr",  mem_addr,   32'h0);
      check("rst_instr",  instr_out,  32'h0);
      check("rst_load",   load_data,  32'h0);
      check("rst_pc",     old_pc_out, 32'h1000);
      reset = 1'b1;
      step();

      // Fetch with minimum latency
      run(2'b00, 3'd0, 32'h1004, 32'h0, 2, 32'h0050_0093);
      check("fetch_done_cyc", d_cyc, 3);
      check("fetch_err",      d_err, 1'b0);
      check("fetch_nreq",     n_req, 1);
      check("fetch_be",       s_be,  4'hF);
      check("fetch_we",       s_we,  1'b0);
      check("fetch_maddr",    s_addr, 32'h1004);
      check("fetch_instr",    instr_out, 32'h0050_0093);
      check("fetch_pc",       old_pc_out, 32'h1004);
      check("fetch_ready",    req_ready, 1'b1);

      // Byte loads at the top lane
      run(2'b01, 3'd0, 32'h2003, 32'h0, 2, 32'h80FF_FF00);
      check("lb_be",   s_be,      4'h1);
      check("lb_addr", s_addr,    32'h2000);
      check("lb_data", load_data, 32'hFFFF_FF80);
      check("lb_cyc",  d_cyc,     3);
      run(2'b01, 3'd4, 32'h2003, 32'h0, 2, 32'h80FF_FF00);
      check("lbu_data", load_data, 32'h0000_0080);

      // Halfword and word loads
      run(2'b01, 3'd1, 32'h2002, 32'h0, 3, 32'h8001_1234);
      check("lh_be",    s_be,      4'h3);
      check("lh_cyc",   d_cyc,     4);
      check("lh_data",  load_data, 32'hFFFF_8001);
      run(2'b01, 3'd5, 32'h2002, 32'h0, 2, 32'h8001_1234);
      check("lhu_data", load_data, 32'h0000_8001);
      run(2'b01, 3'd2, 32'h2000, 32'h0, 2, 32'hDEAD_BEEF);
      check("lw_data",  load_data, 32'hDEAD_BEEF);
      check("lw_err",   d_err,     1'b0);

      // Halfword store with four wait cycles before the ack
      run(2'b10, 3'd1, 32'h2002, 32'h1234_ABCD, 6, 32'h0);
      check("sh_nreq",  n_req,   1);
      check("sh_we",    s_we,    1'b1);
      check("sh_be",    s_be,    4'hC);
      check("sh_wdata", s_wdata, 32'hABCD_0000);
      check("sh_cyc",   d_cyc,   7);
      check("sh_err",   d_err,   1'b0);
      check("sh_load",  load_data, 32'hDEAD_BEEF);

      // Illegal requests
      run(2'b01, 3'd2, 32'h2001, 32'h0, 2, 32'h5555_5555);
      check("mis_cyc",  d_cyc, 1);
      check("mis_err",  d_err, 1'b1);
      check("mis_nreq", n_req, 0);
      check("mis_load", load_data, 32'hDEAD_BEEF);
      run(2'b11, 3'd0, 32'h2000, 32'h0, 2, 32'h5555_5555);
      check("k11_cyc",  d_cyc, 1);
      check("k11_err",  d_err, 1'b1);
      check("k11_nreq", n_req, 0);
      run(2'b10, 3'd4, 32'h2000, 32'h0, 2, 32'h0);
      check("sf3_err",  d_err, 1'b1);
      check("sf3_nreq", n_req, 0);
      run(2'b01, 3'd3, 32'h2000, 32'h0, 2, 32'h0);
      check("lf3_err",  d_err, 1'b1);

      // Timeout, then a late rvalid, then a normal fetch
      run(2'b01, 3'd2, 32'h2004, 32'h0, -1, 32'h0);
      check("to_cyc",  d_cyc, 17);
      check("to_err",  d_err, 1'b1);
      check("to_nreq", n_req, 1);
      check("to_load", load_data, 32'hDEAD_BEEF);
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      step();
      mem_rvalid = 1'b0;
      check("late_done",  done, 1'b0);
      check("late_ready", req_ready, 1'b1);
      check("late_load",  load_data, 32'hDEAD_BEEF);
      run(2'b00, 3'd7, 32'h1008, 32'h0, 2, 32'h0000_0013);
      check("fetch2_cyc",   d_cyc, 3);
      check("fetch2_err",   d_err, 1'b0);
      check("fetch2_instr", instr_out, 32'h0000_0013);
      check("fetch2_pc",    old_pc_out, 32'h1008);

      // Reset while in WAIT
      req_valid = 1'b1; req_kind = 2'b01; funct3 = 3'd2; addr = 32'h2008;
      step();
      req_valid = 1'b0;
      check("rw_issue", mem_req, 1'b1);
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rw_ready",  req_ready,  1'b1);
      check("rw_memreq", mem_req,    1'b0);
      check("rw_pc",     old_pc_out, 32'h1000);
      check("rw_load",   load_data,  32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
      step();
      mem_rvalid = 1'b0;
      check("rw_late_done", done, 1'b0);
      step();
      check("rw_late_done2", done, 1'b0);
      check("rw_late_load",  load_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access sequencer for the multicycle RV32/RV64 core. It sits between the control FSM and the shared instruction/data memory. It serialises fetch, load and store requests over a variable-latency valid/ack memory port, and captures fetched instructions into an instruction register together with their PC. Loads are returned as sign/zero-extended data, stores produce byte-enable masks, and misaligned accesses, illegal widths and memory timeouts are reported as errors instead of silently corrupting state.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- RESET_PC, 32'h1000, reset value of `old_pc_out`
- TIMEOUT, 15, maximum cycles spent in WAIT before the access is aborted; range 1–255
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- req_valid  in  1  request strobe from control FSM
- req_ready  out  1  high only in IDLE
- req_kind  in  2  00 fetch, 01 load, 10 store; 11 illegal
- funct3  in  3  access width/sign as in RV load/store encoding
- addr  in  XLEN  byte address
- wdata  in  XLEN  store data, right-aligned
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; high on misalign, illegal kind/funct3 or timeout
- instr_out  out  32  instruction register
- old_pc_out  out  XLEN  address of the instruction held in instr_out
- load_data  out  XLEN  extended load result
- mem_req  out  1  one-cycle memory request
- mem_we  out  1  write qualifier for mem_req
- mem_addr  out  XLEN  `addr` with low log2(XLEN/8) bits cleared
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rvalid  in  1  read-data valid / write ack
- mem_rdata  in  XLEN  read data, whole word

## Operation
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch kind, funct3, addr and wdata.
  - Go to FIN with err pending if the request is illegal; otherwise go to ISSUE.
- Illegal requests:
  - req_kind=11.
  - funct3 not legal for the kind:
    - Loads: 0,1,2,4,5; XLEN=64 also allows 3 and 6.
    - Stores: 0,1,2; XLEN=64 also allows 3.
    - Fetch ignores funct3 and is always a 32-bit access.
  - Address not naturally aligned: halfword addr[0]≠0, word addr[1:0]≠0, double addr[2:0]≠0.
- ISSUE:
  - mem_req=1 for exactly one cycle; mem_we=1 for stores.
  - mem_addr, mem_be and mem_wdata are held stable from ISSUE until leaving WAIT.
  - Go to WAIT and clear the timeout counter.
- Byte lanes:
  - off = addr[log2(XLEN/8)-1:0].
  - mem_be = size mask (1/3/F/FF) << off; loads and fetch drive the size mask of the access.
  - mem_wdata = wdata << (8·off).
- WAIT:
  - If mem_rvalid, capture the result and go to FIN (err=0).
  - Otherwise increment the counter; when it reaches TIMEOUT, go to FIN with err=1 and capture nothing.
- Capture on mem_rvalid:
  - Fetch: instr_out ← 32-bit lane at off; old_pc_out ← addr.
  - Load: load_data ← (mem_rdata >> 8·off), truncated to size, sign-extended (funct3 0,1,2,3) or zero-extended (4,5,6).
  - Store: no data capture.
- FIN: done=1 for one cycle, err valid; go to IDLE.
- An error never modifies instr_out, old_pc_out or load_data.
- req_valid outside IDLE is ignored and not queued.
- mem_rvalid in IDLE, ISSUE or FIN is ignored.

## Timing
- Reset values:
  - State IDLE, req_ready=1.
  - done, err, mem_req, mem_we = 0.
  - mem_be, mem_addr, mem_wdata, load_data, instr_out = 0.
  - old_pc_out = RESET_PC.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Request accepted in cycle 0, mem_req high in cycle 1.
- mem_rvalid is legal from cycle 2 onward; rvalid sampled in cycle N gives done in cycle N+1.
- Minimum latency: 3 cycles accept-to-done.
- Illegal request: done+err in cycle 1, and mem_req is never asserted.
- Timeout: done+err in cycle 2+TIMEOUT when rvalid never arrives.
- Back-to-back: a new request can be accepted in the cycle after done.
- Reset mid-operation: IDLE with mem_req=0 on the next edge. A late rvalid after reset is ignored.

## Test plan
- Fetch at addr 0x1004, rvalid in cycle 2 with rdata 0x00500093 -> done cycle 3, err=0, instr_out=0x00500093, old_pc_out=0x1004, mem_be=F.
- LB at 0x2003, rdata 0x80FF_FF00 -> mem_be=1, load_data=0xFFFFFF80. LBU at the same address -> load_data=0x00000080.
- SH wdata 0x1234ABCD at 0x2002 -> mem_req for 1 cycle, mem_we=1, mem_be=C, mem_wdata=0xABCD0000. Ack after 4 wait cycles -> done, err=0.
- LW at 0x2001 -> done+err in cycle 1, mem_req never high, load_data unchanged. req_kind=11 -> same response.
- Load with rvalid withheld, TIMEOUT=15 -> done+err in cycle 17. A later rvalid is ignored and the following fetch completes normally.
- reset low during WAIT -> next cycle IDLE, req_ready=1, old_pc_out=0x1000. rvalid one cycle later produces no done.
